// File: rtl/cuckoo_pkg.sv
// Shared definitions for the cuckoo hash engine.
// Contents: request op encodings, response status encodings, the FSM state
// type, the per-way hash seeds and a constant clog2 helper.
package cuckoo_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_RSVD   = 2'd3   // behaves as a lookup
    } op_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NOT_FOUND = 2'd1,
        ST_FULL      = 2'd2
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_KICK  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int MAX_WAYS = 4;

    // One seed per way; only the low KEY_W bits take part in the hash.
    localparam logic [63:0] SEED [MAX_WAYS] = '{
        64'h0000_0000,
        64'hFFFF_FFFF,
        64'hAAAA_AAAA,
        64'h5555_5555
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cuckoo_hash_engine_if.sv
// Request/response bus of the cuckoo hash engine.
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; the requester holds op/key/val stable while
// req_valid=1 and req_ready=0. There is no response backpressure:
// rsp_valid is a single-cycle strobe and rsp_status/rsp_val are only
// meaningful (and otherwise 0) while it is high.
// master: requester side (drives req_*).  slave: engine side.
interface cuckoo_hash_engine_if #(
    parameter int KEY_W = 32,
    parameter int VAL_W = 32,
    parameter int OCC_W = 9
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [KEY_W-1:0] req_key;
    logic [VAL_W-1:0] req_val;
    logic             rsp_valid;
    logic [1:0]       rsp_status;
    logic [VAL_W-1:0] rsp_val;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output req_valid, req_op, req_key, req_val,
        input  req_ready, rsp_valid, rsp_status, rsp_val, occupancy
    );

    modport slave (
        input  req_valid, req_op, req_key, req_val,
        output req_ready, rsp_valid, rsp_status, rsp_val, occupancy
    );
endinterface

// File: rtl/cuckoo_hash_fold.sv
// Combinational per-way hash: x = key ^ SEED, zero-extended to a whole
// number of IDX_W-bit chunks; the index is the XOR of all chunks.
// Ports: i_key (KEY_W) in, o_idx (IDX_W) out.
module cuckoo_hash_fold #(
    parameter int          KEY_W = 32,
    parameter int          IDX_W = 6,
    parameter logic [63:0] SEED  = 64'h0
) (
    input  logic [KEY_W-1:0] i_key,
    output logic [IDX_W-1:0] o_idx
);
    localparam int             NCH    = (KEY_W + IDX_W - 1) / IDX_W;
    localparam logic [KEY_W-1:0] SEED_K = SEED[KEY_W-1:0];

    logic [NCH*IDX_W-1:0] w_x;

    always_comb begin
        w_x            = '0;
        w_x[KEY_W-1:0] = i_key ^ SEED_K;
        o_idx          = '0;
        for (int c = 0; c < NCH; c++) begin
            o_idx = o_idx ^ w_x[c*IDX_W +: IDX_W];
        end
    end
endmodule

// File: rtl/cuckoo_hash_engine.sv
// Multi-way cuckoo hash table with a one-entry stash.
// Ports: clk, rst (async, active-high); bus (slave modport of
// cuckoo_hash_engine_if: request handshake, response strobe, occupancy);
// o_dbg_state (current FSM state).
// Flow: IDLE accepts one request, PROBE looks at every way and the stash,
// KICK displaces entries for an insert that found no free slot, RESP emits
// the one-cycle response.
module cuckoo_hash_engine
    import cuckoo_pkg::*;
#(
    parameter int KEY_W     = 32,
    parameter int VAL_W     = 32,
    parameter int WAYS      = 3,
    parameter int DEPTH     = 64,
    parameter int MAX_KICKS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cuckoo_hash_engine_if.slave  bus,
    output state_t               o_dbg_state
);
    localparam int         IDX_W    = clog2(DEPTH);
    localparam int         OCC_W    = IDX_W + WAYS;
    localparam int         WAY_W    = clog2(WAYS);
    localparam logic [7:0] KICK_LIM = 8'(MAX_KICKS);

    state_t             r_state, w_state_nxt;
    op_t                r_op;
    logic [KEY_W-1:0]   r_key;
    logic [VAL_W-1:0]   r_val;

    logic [KEY_W-1:0]   r_tkey [WAYS][DEPTH];
    logic [VAL_W-1:0]   r_tval [WAYS][DEPTH];
    logic [DEPTH-1:0]   r_tvld [WAYS];
    logic               r_stash_vld;
    logic [KEY_W-1:0]   r_stash_key;
    logic [VAL_W-1:0]   r_stash_val;

    // Item currently being displaced, next victim way and kick count.
    logic [KEY_W-1:0]   r_ckey;
    logic [VAL_W-1:0]   r_cval;
    logic [WAY_W-1:0]   r_vway;
    logic [7:0]         r_kicks;

    logic [1:0]         r_status;
    logic [VAL_W-1:0]   r_rsp_val;
    logic [OCC_W-1:0]   r_occ;

    logic [IDX_W-1:0]   w_ridx [WAYS];
    logic [IDX_W-1:0]   w_cidx [WAYS];

    genvar g;
    generate
        for (g = 0; g < WAYS; g++) begin : g_hash
            cuckoo_hash_fold #(.KEY_W(KEY_W), .IDX_W(IDX_W), .SEED(SEED[g])) u_req_hash (
                .i_key(r_key), .o_idx(w_ridx[g])
            );
            cuckoo_hash_fold #(.KEY_W(KEY_W), .IDX_W(IDX_W), .SEED(SEED[g])) u_carry_hash (
                .i_key(r_ckey), .o_idx(w_cidx[g])
            );
        end
    endgenerate

    // Probe results; "lowest way wins" is realised by scanning downwards.
    logic [WAYS-1:0]  w_rhit, w_rempty, w_cempty;
    logic [WAY_W-1:0] w_rhit_way, w_rempty_way, w_cempty_way;
    logic             w_shit;

    always_comb begin
        w_rhit_way   = '0;
        w_rempty_way = '0;
        w_cempty_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_rhit[w]   = r_tvld[w][w_ridx[w]] && (r_tkey[w][w_ridx[w]] == r_key);
            w_rempty[w] = !r_tvld[w][w_ridx[w]];
            w_cempty[w] = !r_tvld[w][w_cidx[w]];
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_rhit[w])   w_rhit_way   = WAY_W'(w);
            if (w_rempty[w]) w_rempty_way = WAY_W'(w);
            if (w_cempty[w]) w_cempty_way = WAY_W'(w);
        end
        w_shit = r_stash_vld && (r_stash_key == r_key);
    end

    logic             w_accept;
    logic             w_tw_en, w_tclr_en, w_sw_en, w_sclr, w_carry_ld;
    logic [WAY_W-1:0] w_tw_way, w_tclr_way, w_vway_nxt;
    logic [IDX_W-1:0] w_tw_idx, w_tclr_idx;
    logic [KEY_W-1:0] w_tw_key, w_sw_key, w_carry_key;
    logic [VAL_W-1:0] w_tw_val, w_sw_val, w_carry_val;
    logic [7:0]       w_kicks_nxt;
    logic             w_occ_inc, w_occ_dec, w_rsp_ld;
    status_t          w_rsp_status;
    logic [VAL_W-1:0] w_rsp_val;

    assign w_accept = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_tw_en      = 1'b0;
        w_tw_way     = '0;
        w_tw_idx     = '0;
        w_tw_key     = r_key;
        w_tw_val     = r_val;
        w_tclr_en    = 1'b0;
        w_tclr_way   = '0;
        w_tclr_idx   = '0;
        w_sw_en      = 1'b0;
        w_sw_key     = r_key;
        w_sw_val     = r_val;
        w_sclr       = 1'b0;
        w_carry_ld   = 1'b0;
        w_carry_key  = r_key;
        w_carry_val  = r_val;
        w_vway_nxt   = '0;
        w_kicks_nxt  = '0;
        w_occ_inc    = 1'b0;
        w_occ_dec    = 1'b0;
        w_rsp_ld     = 1'b0;
        w_rsp_status = ST_NOT_FOUND;
        w_rsp_val    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_PROBE;
            end
            S_PROBE: begin
                w_state_nxt = S_RESP;
                w_rsp_ld    = 1'b1;
                case (r_op)
                    OP_INSERT: begin
                        w_rsp_status = ST_OK;
                        if (|w_rhit) begin
                            w_tw_en  = 1'b1;
                            w_tw_way = w_rhit_way;
                            w_tw_idx = w_ridx[w_rhit_way];
                        end else if (w_shit) begin
                            w_sw_en = 1'b1;
                        end else if (|w_rempty) begin
                            w_tw_en   = 1'b1;
                            w_tw_way  = w_rempty_way;
                            w_tw_idx  = w_ridx[w_rempty_way];
                            w_occ_inc = 1'b1;
                        end else if (r_stash_vld) begin
                            w_rsp_status = ST_FULL;
                        end else begin
                            // Start displacing with the new item as carry.
                            w_rsp_ld    = 1'b0;
                            w_carry_ld  = 1'b1;
                            w_state_nxt = S_KICK;
                        end
                    end
                    OP_DELETE: begin
                        if (|w_rhit) begin
                            w_tclr_en    = 1'b1;
                            w_tclr_way   = w_rhit_way;
                            w_tclr_idx   = w_ridx[w_rhit_way];
                            w_occ_dec    = 1'b1;
                            w_rsp_status = ST_OK;
                        end else if (w_shit) begin
                            w_sclr       = 1'b1;
                            w_occ_dec    = 1'b1;
                            w_rsp_status = ST_OK;
                        end
                    end
                    default: begin
                        if (|w_rhit) begin
                            w_rsp_status = ST_OK;
                            w_rsp_val    = r_tval[w_rhit_way][w_ridx[w_rhit_way]];
                        end else if (w_shit) begin
                            w_rsp_status = ST_OK;
                            w_rsp_val    = r_stash_val;
                        end
                    end
                endcase
            end
            S_KICK: begin
                w_tw_en  = 1'b1;
                w_tw_key = r_ckey;
                w_tw_val = r_cval;
                if (|w_cempty) begin
                    w_tw_way     = w_cempty_way;
                    w_tw_idx     = w_cidx[w_cempty_way];
                    w_occ_inc    = 1'b1;
                    w_rsp_ld     = 1'b1;
                    w_rsp_status = ST_OK;
                    w_state_nxt  = S_RESP;
                end else begin
                    // Swap carry with the victim; the victim becomes the carry.
                    w_tw_way    = r_vway;
                    w_tw_idx    = w_cidx[r_vway];
                    w_carry_key = r_tkey[r_vway][w_cidx[r_vway]];
                    w_carry_val = r_tval[r_vway][w_cidx[r_vway]];
                    if ((r_kicks + 8'd1) == KICK_LIM) begin
                        w_sw_en      = 1'b1;
                        w_sw_key     = w_carry_key;
                        w_sw_val     = w_carry_val;
                        w_occ_inc    = 1'b1;
                        w_rsp_ld     = 1'b1;
                        w_rsp_status = ST_OK;
                        w_state_nxt  = S_RESP;
                    end else begin
                        w_carry_ld  = 1'b1;
                        w_vway_nxt  = (r_vway == WAY_W'(WAYS - 1)) ? '0 : r_vway + 1'b1;
                        w_kicks_nxt = r_kicks + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= OP_LOOKUP;
            r_key       <= '0;
            r_val       <= '0;
            r_stash_vld <= 1'b0;
            r_stash_key <= '0;
            r_stash_val <= '0;
            r_ckey      <= '0;
            r_cval      <= '0;
            r_vway      <= '0;
            r_kicks     <= '0;
            r_status    <= '0;
            r_rsp_val   <= '0;
            r_occ       <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_tvld[w] <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    r_tkey[w][d] <= '0;
                    r_tval[w][d] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                r_op  <= op_t'(bus.req_op);
                r_key <= bus.req_key;
                r_val <= bus.req_val;
            end
            if (w_tw_en) begin
                r_tvld[w_tw_way][w_tw_idx] <= 1'b1;
                r_tkey[w_tw_way][w_tw_idx] <= w_tw_key;
                r_tval[w_tw_way][w_tw_idx] <= w_tw_val;
            end
            if (w_tclr_en) r_tvld[w_tclr_way][w_tclr_idx] <= 1'b0;
            if (w_sw_en) begin
                r_stash_vld <= 1'b1;
                r_stash_key <= w_sw_key;
                r_stash_val <= w_sw_val;
            end else if (w_sclr) begin
                r_stash_vld <= 1'b0;
            end
            if (w_carry_ld) begin
                r_ckey  <= w_carry_key;
                r_cval  <= w_carry_val;
                r_vway  <= w_vway_nxt;
                r_kicks <= w_kicks_nxt;
            end
            if (w_occ_inc)      r_occ <= r_occ + 1'b1;
            else if (w_occ_dec) r_occ <= r_occ - 1'b1;
            if (w_rsp_ld) begin
                r_status  <= w_rsp_status;
                r_rsp_val <= w_rsp_val;
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE) && !rst;
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_status = bus.rsp_valid ? r_status  : '0;
    assign bus.rsp_val    = bus.rsp_valid ? r_rsp_val : '0;
    assign bus.occupancy  = r_occ;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_cuckoo_hash_engine.sv
// Directed bench for cuckoo_hash_engine in a small configuration
// (2 ways x 4 entries, 4 kicks). With KEY_W=32 and IDX_W=2 both way hashes
// reduce to the same index, so keys 0x0, 0x5, 0xA, 0xF all land on index 0.
module tb_cuckoo_hash_engine;
  import cuckoo_pkg::*;

  localparam int KEY_W     = 32;
  localparam int VAL_W     = 32;
  localparam int WAYS      = 2;
  localparam int DEPTH     = 4;
  localparam int MAX_KICKS = 4;
  localparam int OCC_W     = 2 + WAYS;
  localparam int RW        = 2 + VAL_W;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  always #5 clk = ~clk;

  cuckoo_hash_engine_if #(.KEY_W(KEY_W), .VAL_W(VAL_W), .OCC_W(OCC_W)) bus ();

  cuckoo_hash_engine #(
    .KEY_W(KEY_W), .VAL_W(VAL_W), .WAYS(WAYS), .DEPTH(DEPTH), .MAX_KICKS(MAX_KICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int last_lat = 0;
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for its response and score it.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [KEY_W-1:0] key,
                        input logic [VAL_W-1:0] val, input logic [1:0] exp_st,
                        input logic [VAL_W-1:0] exp_val, input int exp_occ);
    logic [RW-1:0] exp_e;
    int guard;
    int lat;
    exp_q.push_back({exp_st, exp_val});
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_key   = key;
    bus.req_val   = val;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk({tag, " accept"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.rsp_valid !== 1'b1 && lat < 40);
    last_lat = lat;
    chk({tag, " rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    if (bus.rsp_valid === 1'b1 && exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      chk({tag, " status"}, 64'(bus.rsp_status), 64'(exp_e[RW-1 -: 2]));
      chk({tag, " val"}, 64'(bus.rsp_val), 64'(exp_e[VAL_W-1:0]));
      chk({tag, " occ"}, 64'(bus.occupancy), 64'(exp_occ));
      @(negedge clk);
      chk({tag, " pulse"}, 64'(bus.rsp_valid), 64'd0);
    end else begin
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_key   = '0;
    bus.req_val   = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst ready", 64'(bus.req_ready), 64'd0);
    chk("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst occ", 64'(bus.occupancy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after rst", 64'(bus.req_ready), 64'd1);
    chk("idle after rst", 64'(dbg_state), 64'(S_IDLE));

    // Basic lookup/insert, key 0 legal.
    do_req("lookup 0 empty", OP_LOOKUP, 32'h0, 32'h0, ST_NOT_FOUND, 32'h0, 0);
    do_req("insert 5", OP_INSERT, 32'h5, 32'hA5, ST_OK, 32'h0, 1);
    chk("simple latency", 64'(last_lat), 64'd3);
    do_req("lookup 5", OP_LOOKUP, 32'h5, 32'h0, ST_OK, 32'hA5, 1);
    do_req("lookup 6", OP_LOOKUP, 32'h6, 32'h0, ST_NOT_FOUND, 32'h0, 1);
    do_req("insert 0", OP_INSERT, 32'h0, 32'h11, ST_OK, 32'h0, 2);
    do_req("lookup 0", OP_LOOKUP, 32'h0, 32'h0, ST_OK, 32'h11, 2);

    // Overwrite of an existing key.
    do_req("insert 5 v1", OP_INSERT, 32'h5, 32'h1, ST_OK, 32'h0, 2);
    do_req("insert 5 v2", OP_INSERT, 32'h5, 32'h2, ST_OK, 32'h0, 2);
    do_req("lookup 5 upd", OP_LOOKUP, 32'h5, 32'h0, ST_OK, 32'h2, 2);

    // Index 0 is full in both ways: four kicks, last carry (key 5) to stash.
    do_req("insert F kick", OP_INSERT, 32'hF, 32'hF0, ST_OK, 32'h0, 3);
    chk("kick latency", 64'(last_lat), 64'd7);
    chk("kick latency gt 3", 64'(last_lat > 3), 64'd1);
    do_req("lookup 5 stash", OP_LOOKUP, 32'h5, 32'h0, ST_OK, 32'h2, 3);
    do_req("lookup 0 moved", OP_LOOKUP, 32'h0, 32'h0, ST_OK, 32'h11, 3);
    do_req("lookup F", OP_LOOKUP, 32'hF, 32'h0, ST_OK, 32'hF0, 3);
    do_req("rsvd op lookup F", 2'd3, 32'hF, 32'h0, ST_OK, 32'hF0, 3);

    // Stash occupied: further collision is rejected.
    do_req("insert A full", OP_INSERT, 32'hA, 32'hAA, ST_FULL, 32'h0, 3);
    do_req("lookup A", OP_LOOKUP, 32'hA, 32'h0, ST_NOT_FOUND, 32'h0, 3);

    // Deletes from a way and from the stash.
    do_req("delete 0", OP_DELETE, 32'h0, 32'h0, ST_OK, 32'h0, 2);
    do_req("lookup 0 gone", OP_LOOKUP, 32'h0, 32'h0, ST_NOT_FOUND, 32'h0, 2);
    do_req("delete 0 again", OP_DELETE, 32'h0, 32'h0, ST_NOT_FOUND, 32'h0, 2);
    do_req("delete 5 stash", OP_DELETE, 32'h5, 32'h0, ST_OK, 32'h0, 1);
    do_req("lookup 5 gone", OP_LOOKUP, 32'h5, 32'h0, ST_NOT_FOUND, 32'h0, 1);

    // Refill index 0, then start a kicking insert and reset in the middle.
    do_req("insert 5 refill", OP_INSERT, 32'h5, 32'h55, ST_OK, 32'h0, 2);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = OP_INSERT;
    bus.req_key   = 32'hA;
    bus.req_val   = 32'hBB;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("in kick", 64'(dbg_state), 64'(S_KICK));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort occ", 64'(bus.occupancy), 64'd0);
    chk("abort ready", 64'(bus.req_ready), 64'd0);
    chk("abort rsp_valid", 64'(bus.rsp_valid), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("no rsp in rst", 64'(bus.rsp_valid), 64'd0);
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("no rsp after abort", 64'(bus.rsp_valid), 64'd0);
    end
    chk("ready after abort", 64'(bus.req_ready), 64'd1);
    do_req("lookup 5 cleared", OP_LOOKUP, 32'h5, 32'h0, ST_NOT_FOUND, 32'h0, 0);
    do_req("lookup F cleared", OP_LOOKUP, 32'hF, 32'h0, ST_NOT_FOUND, 32'h0, 0);
    do_req("lookup A cleared", OP_LOOKUP, 32'hA, 32'h0, ST_NOT_FOUND, 32'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
